// File: rtl/s2p_pkg.sv
// Shared types and front-end defaults for the serial-to-parallel packer.
// The state encoding is fixed so the FILL/HOLD bit can be probed directly.
package s2p_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int S2P_IN_W  = 8;
    localparam int S2P_WORDS = 8;

endpackage

// File: rtl/s2p_packer.sv
// Packs WORDS input beats of IN_W bits into one word with sign, beat count and
// partial flag, behind a valid/ready output register with one-word backpressure hold.
module s2p_packer
    import s2p_pkg::*;
#(
    parameter  int IN_W  = S2P_IN_W,
    parameter  int WORDS = S2P_WORDS,
    localparam int OUT_W = IN_W * WORDS,
    localparam int CNT_W = $clog2(WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sign,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sign,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_partial
);

    state_t             state, state_nx;
    logic [OUT_W-1:0]   acc, acc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               hold_sign, hold_sign_nx;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
    logic               hold_partial, hold_partial_nx;

    logic               out_valid_nx;
    logic [OUT_W-1:0]   out_data_nx;
    logic               out_sign_nx;
    logic [CNT_W-1:0]   out_cnt_nx;
    logic               out_partial_nx;

    logic               accept;
    logic               last_slot;
    logic               completing;
    logic               slot_free;
    logic               beat_partial;
    logic [OUT_W-1:0]   pack_val;
    logic [CNT_W-1:0]   cnt_inc;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready     = (state == S_FILL);
    assign accept       = in_valid & in_ready;
    assign last_slot    = (cnt == CNT_W'(WORDS - 1));
    assign completing   = accept & (last_slot | in_last);
    assign slot_free    = ~out_valid | out_ready;
    assign beat_partial = in_last & ~last_slot;
    assign pack_val     = {acc[OUT_W-IN_W-1:0], in_data};
    assign cnt_inc      = cnt + CNT_W'(1);

    always_comb begin
        state_nx        = state;
        acc_nx          = acc;
        cnt_nx          = cnt;
        hold_sign_nx    = hold_sign;
        hold_cnt_nx     = hold_cnt;
        hold_partial_nx = hold_partial;
        out_valid_nx    = out_valid & ~out_ready;
        out_data_nx     = out_data;
        out_sign_nx     = out_sign;
        out_cnt_nx      = out_cnt;
        out_partial_nx  = out_partial;

        unique case (state)
            S_FILL: begin
                if (completing) begin
                    if (slot_free) begin
                        out_valid_nx   = 1'b1;
                        out_data_nx    = pack_val;
                        out_sign_nx    = in_sign;
                        out_cnt_nx     = cnt_inc;
                        out_partial_nx = beat_partial;
                        acc_nx         = '0;
                        cnt_nx         = '0;
                    end else begin
                        // Park the finished word in acc until the output slot frees.
                        acc_nx          = pack_val;
                        hold_sign_nx    = in_sign;
                        hold_cnt_nx     = cnt_inc;
                        hold_partial_nx = beat_partial;
                        state_nx        = S_HOLD;
                    end
                end else if (accept) begin
                    acc_nx = pack_val;
                    cnt_nx = cnt_inc;
                end
            end
            S_HOLD: begin
                if (slot_free) begin
                    out_valid_nx   = 1'b1;
                    out_data_nx    = acc;
                    out_sign_nx    = hold_sign;
                    out_cnt_nx     = hold_cnt;
                    out_partial_nx = hold_partial;
                    acc_nx         = '0;
                    cnt_nx         = '0;
                    state_nx       = S_FILL;
                end
            end
            default: state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FILL;
            acc          <= '0;
            cnt          <= '0;
            hold_sign    <= 1'b0;
            hold_cnt     <= '0;
            hold_partial <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sign     <= 1'b0;
            out_cnt      <= '0;
            out_partial  <= 1'b0;
        end else begin
            state        <= state_nx;
            acc          <= acc_nx;
            cnt          <= cnt_nx;
            hold_sign    <= hold_sign_nx;
            hold_cnt     <= hold_cnt_nx;
            hold_partial <= hold_partial_nx;
            out_valid    <= out_valid_nx;
            out_data     <= out_data_nx;
            out_sign     <= out_sign_nx;
            out_cnt      <= out_cnt_nx;
            out_partial  <= out_partial_nx;
        end
    end

endmodule

// File: doc/s2p_packer.md
Name: s2p_packer

Overview:
Parametrised serial-to-parallel packer and successor to the fixed 8x8-bit packer. Accepts IN_W-bit beats on a valid/ready input, packs WORDS beats into one OUT_W-bit word, and presents it with a sign sideband on a valid/ready output. Adds an output holding register with backpressure, early termination of partial words via in_last, and a beat count on every output word. Sits between the byte-stream front end and the divider operand FIFO.

Parameters:
IN_W, 8, width of one input beat in bits
WORDS, 8, beats per full output word; must be >= 2
OUT_W, IN_W*WORDS, derived localparam and not overridable; packed data width
CNT_W, $clog2(WORDS+1), derived localparam; width of the beat counter and out_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  packer can accept a beat
in_data  in  IN_W  input beat
in_sign  in  1  sign sideband, sampled on the completing beat only
in_last  in  1  marks the final beat of a partial word
out_valid  out  1  packed word valid
out_ready  in  1  downstream (FIFO not full) accepts the word
out_data  out  OUT_W  packed word
out_sign  out  1  sign of the packed word
out_cnt  out  CNT_W  number of beats in the word (1..WORDS)
out_partial  out  1  word was closed by in_last before WORDS beats

Behaviour:
- Reset (asynchronous, while rst=1): state=FILL, acc=0, cnt=0, out_valid=0, out_data=0, out_sign=0, out_cnt=0, out_partial=0, in_ready=1 once rst is deasserted.
- Beat accepted when in_valid & in_ready. in_ready = (state==FILL) and is a registered-state decode with no combinational path from out_ready.
- Packing: acc <= {acc[OUT_W-IN_W-1:0], in_data}. The first beat of a word ends up most significant among the beats received. For a partial word, the data sits in the low cnt*IN_W bits and the upper bits are zero.
- Completing beat: the accepted beat with cnt==WORDS-1, or any accepted beat with in_last=1. When in_last coincides with the WORDS-th beat, the word is full (out_partial=0).
- On a completing beat in FILL:
  - if !out_valid | out_ready: load the output register the next cycle from the packed value including this beat. out_sign=in_sign, out_cnt=cnt+1, out_partial=in_last&(cnt+1<WORDS). Clear acc and cnt. Stay in FILL.
  - else: store the packed value, sign, count and partial flag into acc and its side registers, then go to HOLD.
- HOLD: in_ready=0. When !out_valid | out_ready, transfer acc to the output register, clear acc and cnt, and return to FILL. This gives one bubble cycle.
- Output register: out_valid is set on load and cleared on out_valid&out_ready with no new load. A drain and a load in the same cycle keep out_valid=1 with the new data. Outputs hold stable while out_valid&!out_ready.
- Latency: out_valid is asserted the cycle after the completing beat is accepted, when the output slot is free.
- Throughput: 1 beat/cycle sustained while out_ready=1 (WORDS beats per word, no bubbles).
- The sign is captured only on the completing beat. in_sign on earlier beats is ignored.
- The counter wraps to 0 after each completing beat and never reaches WORDS.
- rst asserted mid-word or mid-HOLD discards all partial and held data. No word is emitted.
- An in_valid=0 cycle leaves acc, cnt and state unchanged.

Decomposition:
- Shared package s2p_pkg: state encoding constants (S_FILL=1'b0, S_HOLD=1'b1) and default IN_W/WORDS constants for the divider front end.
- No sub-module. The accumulator, counter, FSM and output register form one block of roughly 150-200 lines.

Test Plan:
- Reset: hold rst=1 with random inputs -> out_valid=0, out_data=0, out_cnt=0. After release, in_ready=1.
- Full word: IN_W=8, WORDS=8; beats 0x01..0x08 back-to-back with out_ready=1 and in_sign=1 on beat 8 -> out_data=64'h0102030405060708, out_sign=1, out_cnt=8, out_partial=0 one cycle after beat 8.
- Backpressure: out_ready=0, push two full words -> the first is held stable, the second completes into HOLD with in_ready=0. Raise out_ready -> words drain in order and FILL resumes after one bubble.
- Partial: beats 0xAA, 0xBB, 0xCC with in_last on 0xCC -> out_data=64'h0000000000AABBCC, out_cnt=3, out_partial=1. The next word starts from cnt=0.
- Reset mid-word: 5 beats, then pulse rst -> no output word. A following 8-beat word packs correctly.
- Parametrised: IN_W=16, WORDS=4, continuous stream with out_ready=1 -> 1 beat/cycle, words of 64 bits with out_cnt=4.
